// File: rtl/photon_round_seq.sv
// PHOTON-256 permutation sequencer: one SBOX + M-column multiply-accumulate step per cycle.
// A round is 64 column steps followed by one commit cycle that swaps the new state in.
module photon_round_seq #(
  parameter int ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_state,
  output logic         busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  logic [1:0]   fsm_reg;
  logic [255:0] st_reg;
  logic [31:0]  nxt_reg [8];
  logic [255:0] nxt_flat;
  logic [31:0]  acc_reg;
  logic [255:0] out_state_reg;
  logic [3:0]   rnd_reg;
  logic [2:0]   col_reg;
  logic [2:0]   row_reg;

  logic [2:0]   src;
  logic [3:0]   raw_nib;
  logic [3:0]   cst_nib;
  logic [3:0]   a_nib;
  logic [3:0]   sb_nib;
  logic [31:0]  m_col;
  logic [31:0]  step_val;
  logic [31:0]  acc_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] rc_of(input logic [3:0] r);
    logic [3:0] y;
    case (r)
      4'd0: y = 4'h1;  4'd1: y = 4'h3;  4'd2:  y = 4'h7;  4'd3:  y = 4'hE;
      4'd4: y = 4'hD;  4'd5: y = 4'hB;  4'd6:  y = 4'h6;  4'd7:  y = 4'hC;
      4'd8: y = 4'h9;  4'd9: y = 4'h2;  4'd10: y = 4'h5;  4'd11: y = 4'hA;
      default: y = 4'h0;
    endcase
    return y;
  endfunction

  function automatic logic [3:0] ic_of(input logic [2:0] r);
    logic [3:0] y;
    case (r)
      3'd0: y = 4'h0;  3'd1: y = 4'h1;  3'd2: y = 4'h3;  3'd3: y = 4'h7;
      3'd4: y = 4'hF;  3'd5: y = 4'hE;  3'd6: y = 4'hC;  default: y = 4'h8;
    endcase
    return y;
  endfunction

  // Column k of the PHOTON-256 mixing matrix; nibble i holds M[i][k].
  function automatic logic [31:0] m_column(input logic [2:0] k);
    logic [31:0] y;
    case (k)
      3'd0: y = 32'hFC9F14C2;
      3'd1: y = 32'h12EC6494;
      3'd2: y = 32'hD2595D82;
      3'd3: y = 32'hAAFD1DDB;
      3'd4: y = 32'h534EC972;
      3'd5: y = 32'hA1C5D478;
      3'd6: y = 32'h219EFD55;
      default: y = 32'h3E6DE926;
    endcase
    return y;
  endfunction

  // GF(2^4) multiply, reduction polynomial x^4 + x + 1.
  function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] p;
    logic [3:0] t;
    p = 4'h0;
    t = x;
    for (int k = 0; k < 4; k++) begin
      if (y[k]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // ShiftRows folded into the operand fetch: row r of output column c comes from column c+r.
  assign src      = col_reg + row_reg;
  assign raw_nib  = st_reg[{src, row_reg, 2'b00} +: 4];
  assign cst_nib  = (src == 3'd0) ? (rc_of(rnd_reg) ^ ic_of(row_reg)) : 4'h0;
  assign a_nib    = raw_nib ^ cst_nib;
  assign sb_nib   = sbox(a_nib);
  assign m_col    = m_column(row_reg);
  assign acc_next = ((row_reg == 3'd0) ? 32'h0 : acc_reg) ^ step_val;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign step_val[4*gi +: 4]  = gf_mul(m_col[4*gi +: 4], sb_nib);
      assign nxt_flat[32*gi +: 32] = nxt_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_reg       <= S_IDLE;
      st_reg        <= '0;
      acc_reg       <= '0;
      out_state_reg <= '0;
      rnd_reg       <= '0;
      col_reg       <= '0;
      row_reg       <= '0;
      for (int k = 0; k < 8; k++) nxt_reg[k] <= '0;
    end else begin
      case (fsm_reg)
        S_IDLE: begin
          if (in_valid) begin
            st_reg  <= in_state;
            rnd_reg <= '0;
            col_reg <= '0;
            row_reg <= '0;
            fsm_reg <= S_RUN;
          end
        end
        S_RUN: begin
          acc_reg <= acc_next;
          row_reg <= row_reg + 3'd1;
          if (row_reg == 3'd7) begin
            nxt_reg[col_reg] <= acc_next;
            col_reg          <= col_reg + 3'd1;
            if (col_reg == 3'd7) fsm_reg <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          st_reg  <= nxt_flat;
          col_reg <= '0;
          row_reg <= '0;
          if (rnd_reg == LAST_RND) begin
            rnd_reg       <= '0;
            out_state_reg <= nxt_flat;
            fsm_reg       <= S_DONE;
          end else begin
            rnd_reg <= rnd_reg + 4'd1;
            fsm_reg <= S_RUN;
          end
        end
        S_DONE: begin
          if (out_ready) fsm_reg <= S_IDLE;
        end
        default: fsm_reg <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (fsm_reg == S_IDLE);
  assign out_valid = (fsm_reg == S_DONE);
  assign busy      = (fsm_reg == S_RUN) || (fsm_reg == S_COMMIT);
  assign out_state = out_state_reg;

endmodule
